// File: rtl/mem_block_mover_if.sv
// Bundle of the mover's control-side request/status signals and its data-memory port.
// The slave modport is the mover; the master modport is the controller plus memory around it.
interface mem_block_mover_if #(
    parameter int AW = 8
);
    logic          Start;
    logic          Mode;
    logic [AW-1:0] SrcAddr;
    logic [AW-1:0] DstAddr;
    logic [AW-1:0] Len;
    logic [7:0]    FillVal;
    logic          Busy;
    logic          Done;
    logic [AW-1:0] DataAddress;
    logic          WriteMem;
    logic [7:0]    DataIn;
    logic [7:0]    DataOut;

    modport slave (
        input  Start, Mode, SrcAddr, DstAddr, Len, FillVal, DataOut,
        output Busy, Done, DataAddress, WriteMem, DataIn
    );

    modport master (
        output Start, Mode, SrcAddr, DstAddr, Len, FillVal, DataOut,
        input  Busy, Done, DataAddress, WriteMem, DataIn
    );
endinterface

// File: rtl/mem_block_mover.sv
// Copies (read then write, two cycles per byte) or fills (one cycle per byte) a
// wrapping region of the 8-bit data memory, then pulses Done for one cycle.
module mem_block_mover #(
    parameter int AW = 8
) (
    input  logic             CLK,
    input  logic             Reset_n,
    mem_block_mover_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, FILL, DONE} state_t;

    state_t        state, state_next;
    logic [AW-1:0] idx;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    logic [7:0]    hold;
    logic [7:0]    fill_val;
    logic          last;

    // One extra bit keeps idx+1 from wrapping back to 0 when len is at its maximum.
    assign last = ({1'b0, idx} + (AW+1)'(1)) == {1'b0, len};

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            src      <= '0;
            dst      <= '0;
            len      <= '0;
            hold     <= '0;
            fill_val <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        src      <= bus.SrcAddr;
                        dst      <= bus.DstAddr;
                        len      <= bus.Len;
                        fill_val <= bus.FillVal;
                        idx      <= '0;
                    end
                end
                READ:        hold <= bus.DataOut;
                WRITE, FILL: idx  <= idx + AW'(1);
                default: ;
            endcase
        end
    end

    // Mode needs no register of its own: the choice of READ or FILL carries it.
    always_comb begin
        state_next      = state;
        bus.Busy        = 1'b0;
        bus.Done        = 1'b0;
        bus.DataAddress = '0;
        bus.WriteMem    = 1'b0;
        bus.DataIn      = '0;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    if (bus.Len == '0)
                        state_next = DONE;
                    else if (bus.Mode)
                        state_next = FILL;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                bus.Busy        = 1'b1;
                bus.DataAddress = src + idx;
                state_next      = WRITE;
            end
            WRITE: begin
                bus.Busy        = 1'b1;
                bus.DataAddress = dst + idx;
                bus.WriteMem    = 1'b1;
                bus.DataIn      = hold;
                state_next      = last ? DONE : READ;
            end
            FILL: begin
                bus.Busy        = 1'b1;
                bus.DataAddress = dst + idx;
                bus.WriteMem    = 1'b1;
                bus.DataIn      = fill_val;
                state_next      = last ? DONE : FILL;
            end
            DONE: begin
                bus.Done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_block_mover.sv
// Scoreboard bench: expected writes and Done cycles are queued at each Start and
// popped by a negedge monitor whenever the mover writes memory or pulses Done.
module tb_mem_block_mover;
    localparam int AW = 8;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic CLK = 1'b0;
    logic Reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    wr_t  wq[$];
    int   dq[$];

    logic [7:0] mem [256];
    logic       pre_we = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [7:0] pre_data = '0;

    mem_block_mover_if #(.AW(AW)) bus ();

    mem_block_mover #(.AW(AW)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign bus.DataOut = mem[bus.DataAddress];

    always @(posedge CLK) begin
        if (bus.WriteMem)
            mem[bus.DataAddress] <= bus.DataIn;
        else if (pre_we)
            mem[pre_addr] <= pre_data;
    end

    // cyc seen here counts edges; the period after Start edge T shows cyc == T.
    always @(negedge CLK) begin
        if (Reset_n) begin
            if (bus.WriteMem) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%02h data=%02h", bus.DataAddress, bus.DataIn);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    if (bus.DataAddress != e.addr || bus.DataIn != e.data) begin
                        errors++;
                        $display("FAIL write got addr=%02h data=%02h expected addr=%02h data=%02h",
                                 bus.DataAddress, bus.DataIn, e.addr, e.data);
                    end
                end
            end
            if (bus.Done) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    int e;
                    e = dq.pop_front();
                    if (cyc != e) begin
                        errors++;
                        $display("FAIL done_cycle got %0d expected %0d", cyc, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge CLK);
        pre_we   = 1'b0;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    // done_off < 0 means no Done is expected for this request.
    task automatic go(input logic mode, input logic [7:0] src, input logic [7:0] dst,
                      input logic [7:0] len, input logic [7:0] fv, input int done_off,
                      input bit hold_start);
        @(negedge CLK);
        bus.Mode    = mode;
        bus.SrcAddr = src;
        bus.DstAddr = dst;
        bus.Len     = len;
        bus.FillVal = fv;
        bus.Start   = 1'b1;
        @(posedge CLK);
        #1;
        if (done_off >= 0) dq.push_back(cyc + done_off);
        if (hold_start) begin
            @(posedge CLK);
            #1;
        end
        bus.Start = 1'b0;
        if (len != 0 && !hold_start) begin
            @(negedge CLK);
            check("busy_after_start", 32'(bus.Busy), 32'd1);
        end
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while ((dq.size() != 0 || wq.size() != 0) && k < bound) begin
            @(negedge CLK);
            k++;
        end
        @(negedge CLK);
        if (dq.size() != 0 || wq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout pending_writes=%0d pending_done=%0d", wq.size(), dq.size());
            wq.delete();
            dq.delete();
        end
    endtask

    initial begin
        bus.Start   = 1'b0;
        bus.Mode    = 1'b0;
        bus.SrcAddr = '0;
        bus.DstAddr = '0;
        bus.Len     = '0;
        bus.FillVal = '0;
        Reset_n     = 1'b0;
        #1;
        check("reset_busy", 32'(bus.Busy), 32'd0);
        check("reset_done", 32'(bus.Done), 32'd0);
        check("reset_we", 32'(bus.WriteMem), 32'd0);
        check("reset_addr", 32'(bus.DataAddress), 32'd0);
        check("reset_din", 32'(bus.DataIn), 32'd0);

        for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
        poke(8'h10, 8'd1); poke(8'h11, 8'd2); poke(8'h12, 8'd3); poke(8'h13, 8'd4);
        poke(8'h20, 8'd7); poke(8'h21, 8'd8); poke(8'h22, 8'd9); poke(8'h23, 8'd10);
        poke(8'h50, 8'h11); poke(8'h51, 8'h22); poke(8'h52, 8'h33);
        @(negedge CLK);
        Reset_n = 1'b1;
        repeat (2) @(negedge CLK);

        // plain copy: 8 busy cycles then Done
        push_wr(8'h40, 8'd1); push_wr(8'h41, 8'd2); push_wr(8'h42, 8'd3); push_wr(8'h43, 8'd4);
        go(1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 8, 1'b0);
        wait_done(40);
        check("copy_m40", 32'(mem[8'h40]), 32'd1);
        check("copy_m43", 32'(mem[8'h43]), 32'd4);

        // fill wrapping past 0xFF
        push_wr(8'hFE, 8'hA5); push_wr(8'hFF, 8'hA5); push_wr(8'h00, 8'hA5); push_wr(8'h01, 8'hA5);
        go(1'b1, 8'h00, 8'hFE, 8'd4, 8'hA5, 4, 1'b0);
        wait_done(40);
        check("fill_m00", 32'(mem[8'h00]), 32'hA5);
        check("fill_m02_untouched", 32'(mem[8'h02]), 32'h00);

        // Len=0, Start also held during DONE and must be ignored there
        go(1'b1, 8'h00, 8'h90, 8'd0, 8'h77, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("len0_quiet", 32'({bus.Busy, bus.WriteMem}), 32'd0);
        end
        wait_done(10);
        check("len0_m90", 32'(mem[8'h90]), 32'h00);

        // forward overlap replicates the first byte
        push_wr(8'h21, 8'd7); push_wr(8'h22, 8'd7); push_wr(8'h23, 8'd7);
        go(1'b0, 8'h20, 8'h21, 8'd3, 8'h00, 6, 1'b0);
        wait_done(40);
        check("overlap_m20", 32'(mem[8'h20]), 32'd7);
        check("overlap_m23", 32'(mem[8'h23]), 32'd7);

        // Start with new operands mid-copy is ignored
        push_wr(8'h60, 8'h11); push_wr(8'h61, 8'h22); push_wr(8'h62, 8'h33);
        go(1'b0, 8'h50, 8'h60, 8'd3, 8'h00, 6, 1'b0);
        @(negedge CLK);
        bus.Mode    = 1'b1;
        bus.SrcAddr = 8'h10;
        bus.DstAddr = 8'h70;
        bus.Len     = 8'd2;
        bus.FillVal = 8'hEE;
        bus.Start   = 1'b1;
        @(negedge CLK);
        bus.Start   = 1'b0;
        wait_done(40);
        check("busy_start_m70", 32'(mem[8'h70]), 32'h00);
        check("busy_start_m62", 32'(mem[8'h62]), 32'h33);

        // reset during the third FILL cycle
        push_wr(8'h80, 8'h3C); push_wr(8'h81, 8'h3C);
        go(1'b1, 8'h00, 8'h80, 8'd6, 8'h3C, -1, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        Reset_n = 1'b0;
        #1;
        check("abort_we", 32'(bus.WriteMem), 32'd0);
        check("abort_outputs", 32'({bus.Busy, bus.Done, bus.DataAddress, bus.DataIn}), 32'd0);
        repeat (3) @(negedge CLK);
        check("abort_pending_writes", 32'(wq.size()), 32'd0);
        wq.delete();
        check("abort_m81", 32'(mem[8'h81]), 32'h3C);
        check("abort_m82", 32'(mem[8'h82]), 32'h00);
        Reset_n = 1'b1;
        @(negedge CLK);

        // maximum length fill after the aborted one
        for (int i = 0; i < 255; i++) push_wr(8'(i), 8'h5A);
        go(1'b1, 8'h00, 8'h00, 8'hFF, 8'h5A, 255, 1'b0);
        wait_done(400);
        check("maxlen_mFE", 32'(mem[8'hFE]), 32'h5A);
        check("maxlen_mFF_untouched", 32'(mem[8'hFF]), 32'hA5);

        repeat (3) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_block_mover.md
# mem_block_mover

Memory-side initiator that copies or fills a contiguous region of the 8-bit data memory without core intervention. It sits between the control path and the data memory's address/write-enable/data ports. It drives the pointer, write enable and write data, and consumes the memory's combinational read data. A copy costs two cycles per byte (read, then write); a fill costs one cycle per byte.

## Interface
Parameters:
- AW, 8, address width; the region wraps modulo 2**AW.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- Reset_n  in  1  reset, asynchronous assert, active-low.
- Start  in  1  request pulse; sampled only in IDLE.
- Mode  in  1  0 = copy, 1 = fill.
- SrcAddr  in  AW  copy source base; ignored in fill mode.
- DstAddr  in  AW  destination base.
- Len  in  AW  byte count, 0..2**AW-1.
- FillVal  in  8  fill byte; ignored in copy mode.
- Busy  out  1  high in READ, WRITE and FILL.
- Done  out  1  one-cycle completion pulse.
- DataAddress  out  AW  memory pointer.
- WriteMem  out  1  memory write enable.
- DataIn  out  8  data to the memory write port.
- DataOut  in  8  memory read data, combinational from DataAddress.

## Operation
- States: IDLE, READ, WRITE, FILL, DONE.
- IDLE, Start=1:
  - Latch SrcAddr, DstAddr, Len, Mode and FillVal. Clear the index i to 0.
  - Next state: DONE if Len=0; otherwise READ (copy) or FILL (fill).
- READ:
  - DataAddress = src+i, WriteMem = 0.
  - At the clock edge, register DataOut into the hold register. Next state WRITE.
- WRITE:
  - DataAddress = dst+i, WriteMem = 1, DataIn = hold.
  - At the clock edge, i increments. If i+1 = len, next state DONE; otherwise READ.
- FILL:
  - DataAddress = dst+i, WriteMem = 1, DataIn = latched FillVal.
  - At the clock edge, i increments. If i+1 = len, next state DONE.
- DONE: Done = 1 for one cycle. Next state IDLE.
- Start outside IDLE is ignored. Latched operands are not affected by input changes during an operation.
- Address arithmetic is AW-bit and wraps silently. Example: AW=8, dst=0xFE, len=4 writes 0xFE, 0xFF, 0x00, 0x01.
- Overlapping copies are strictly forward, byte by byte. With dst = src+1 the first source byte is replicated across the region; this is the defined behaviour.
- IDLE and DONE outputs: DataAddress = 0, WriteMem = 0, DataIn = 0.
- Memory outputs are decoded from the state and the registered index only. They do not depend combinationally on DataOut.

## Timing
- Reset (Reset_n low, asynchronous): state IDLE; i, hold and latched operands cleared to 0; Busy, Done and WriteMem 0; DataAddress 0; DataIn 0.
- Reset during an operation aborts it immediately:
  - WriteMem drops without waiting for a clock edge, and no Done is issued.
  - Bytes already written stay written.
- Start is sampled at edge T. Busy rises in the cycle after T.
- Copy, len = L:
  - READ/WRITE occupy 2L cycles.
  - Done is high in cycle T+2L+1; IDLE follows at T+2L+2.
- Fill, len = L: FILL occupies L cycles; Done is high in cycle T+L+1.
- Len = 0: no memory access; Done is high in cycle T+1, and Busy never rises.
- A new Start is accepted in the cycle after Done (IDLE). Start asserted during DONE is ignored.
- Maximum Len (2**AW-1) terminates correctly; the index compare must not overflow.

## Test plan
- Copy: memory preloaded M[0x10..0x13] = 1,2,3,4; Start with Mode=0, Src=0x10, Dst=0x40, Len=4. Required:
  - M[0x40..0x43] = 1,2,3,4.
  - Done is high exactly 9 cycles after the Start edge.
  - Exactly 4 WriteMem cycles, alternating with reads.
- Fill with wrap: Mode=1, Dst=0xFE, Len=4, FillVal=0xA5. Required:
  - M[0xFE], M[0xFF], M[0x00], M[0x01] = 0xA5; M[0x02] unchanged.
  - Done high 5 cycles after Start.
- Len=0: Start with any mode. Required:
  - Done pulses the next cycle.
  - WriteMem and Busy are never asserted; memory is unchanged.
- Overlapping forward copy: M[0x20..0x23] = 7,8,9,10; Src=0x20, Dst=0x21, Len=3. Required: M[0x21..0x23] = 7,7,7.
- Start while busy: re-pulse Start with different operands mid-copy. Required: the original operation completes unchanged, with exactly one Done pulse.
- Reset mid-fill: drop Reset_n after 2 of 6 FILL cycles. Required:
  - WriteMem falls asynchronously; only the first 2 bytes are written.
  - All outputs return to 0, and there is no Done pulse.
  - A subsequent Start works normally.
